// File: rtl/i2c_slave_rx_ctrl.sv
// ---------------------------------------------------------------------------
// i2c_slave_rx_ctrl
// Bit-level I2C slave receive controller (write path). Oversamples the
// synchronized SCL/SDA on clk, detects START/STOP, strobes a downstream
// 8-bit MSB-first shift register once per data bit, checks the address
// byte, drives ACK/NACK and announces each received data byte.
//
// Optional feature macro: I2C_RX_NACK_ON_FULL_EN
//   defined   : a data byte completing while fifo_full = 1 is NACKed,
//               overrun pulses and the transfer is abandoned until STOP.
//   undefined : the byte is always ACKed; byte_valid pulses and overrun
//               pulses alongside it when fifo_full = 1.
// ---------------------------------------------------------------------------
module i2c_slave_rx_ctrl #(
    parameter logic [6:0] SLAVE_ADDR = 7'h3C
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       scl_in,
    input  logic       sda_in,
    input  logic [7:0] rx_byte,
    input  logic       fifo_full,
    output logic       shift_strobe,
    output logic       sda_drive_low,
    output logic       byte_valid,
    output logic       addr_match,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_DATA      = 3'd3,
        ST_DATA_ACK  = 3'd4,
        ST_WAIT_STOP = 3'd5
    } state_t;

    state_t      state_r, state_nxt_s;
    logic        scl_d_r, sda_d_r;
    logic [2:0]  bit_cnt_r, bit_cnt_nxt_s;
    // Set once the 8th SCL rise of a byte has been seen (bit_cnt wrapped).
    logic        byte_full_r, byte_full_nxt_s;

    logic        scl_rise_s, scl_fall_s, start_s, stop_s;
    logic        strobe_nxt_s, drive_nxt_s, valid_nxt_s;
    logic        match_nxt_s, overrun_nxt_s, busy_nxt_s;

    // True when the received address byte targets us with a write request.
    function automatic logic addr_hit(input logic [7:0] b);
        return (b[7:1] == SLAVE_ADDR) && (b[0] == 1'b0);
    endfunction

    assign scl_rise_s = scl_in & ~scl_d_r;
    assign scl_fall_s = ~scl_in & scl_d_r;
    assign start_s    = scl_in & scl_d_r & ~sda_in & sda_d_r;
    assign stop_s     = scl_in & scl_d_r & sda_in & ~sda_d_r;

    // Next-state and next-output decode; bus conditions outrank SCL edges.
    always_comb begin
        state_nxt_s     = state_r;
        bit_cnt_nxt_s   = bit_cnt_r;
        byte_full_nxt_s = byte_full_r;
        strobe_nxt_s    = 1'b0;
        drive_nxt_s     = sda_drive_low;
        valid_nxt_s     = 1'b0;
        match_nxt_s     = addr_match;
        overrun_nxt_s   = 1'b0;
        busy_nxt_s      = busy;

        if (stop_s) begin
            state_nxt_s     = ST_IDLE;
            bit_cnt_nxt_s   = 3'd0;
            byte_full_nxt_s = 1'b0;
            drive_nxt_s     = 1'b0;
            match_nxt_s     = 1'b0;
            busy_nxt_s      = 1'b0;
        end else if (start_s) begin
            state_nxt_s     = ST_ADDR;
            bit_cnt_nxt_s   = 3'd0;
            byte_full_nxt_s = 1'b0;
            drive_nxt_s     = 1'b0;
            match_nxt_s     = 1'b0;
            busy_nxt_s      = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    drive_nxt_s = 1'b0;
                end
                ST_ADDR, ST_DATA: begin
                    if (scl_rise_s) begin
                        strobe_nxt_s  = 1'b1;
                        bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            byte_full_nxt_s = 1'b1;
                        end else begin
                            byte_full_nxt_s = byte_full_r;
                        end
                    end else if (scl_fall_s && byte_full_r) begin
                        byte_full_nxt_s = 1'b0;
                        if (state_r == ST_ADDR) begin
                            if (addr_hit(rx_byte)) begin
                                state_nxt_s = ST_ADDR_ACK;
                                drive_nxt_s = 1'b1;
                                match_nxt_s = 1'b1;
                            end else begin
                                state_nxt_s = ST_WAIT_STOP;
                                drive_nxt_s = 1'b0;
                            end
                        end else begin
`ifdef I2C_RX_NACK_ON_FULL_EN
                            if (fifo_full) begin
                                overrun_nxt_s = 1'b1;
                                state_nxt_s   = ST_WAIT_STOP;
                                drive_nxt_s   = 1'b0;
                            end else begin
                                valid_nxt_s = 1'b1;
                                state_nxt_s = ST_DATA_ACK;
                                drive_nxt_s = 1'b1;
                            end
`else
                            valid_nxt_s   = 1'b1;
                            overrun_nxt_s = fifo_full;
                            state_nxt_s   = ST_DATA_ACK;
                            drive_nxt_s   = 1'b1;
`endif
                        end
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_ADDR_ACK, ST_DATA_ACK: begin
                    if (scl_fall_s) begin
                        state_nxt_s     = ST_DATA;
                        drive_nxt_s     = 1'b0;
                        bit_cnt_nxt_s   = 3'd0;
                        byte_full_nxt_s = 1'b0;
                    end else begin
                        drive_nxt_s = 1'b1;
                    end
                end
                ST_WAIT_STOP: begin
                    drive_nxt_s = 1'b0;
                end
                default: begin
                    state_nxt_s     = ST_IDLE;
                    bit_cnt_nxt_s   = 3'd0;
                    byte_full_nxt_s = 1'b0;
                    drive_nxt_s     = 1'b0;
                    match_nxt_s     = 1'b0;
                    busy_nxt_s      = 1'b0;
                end
            endcase
        end
    end

    // State, edge-detect history and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r       <= ST_IDLE;
            scl_d_r       <= 1'b1;
            sda_d_r       <= 1'b1;
            bit_cnt_r     <= 3'd0;
            byte_full_r   <= 1'b0;
            shift_strobe  <= 1'b0;
            sda_drive_low <= 1'b0;
            byte_valid    <= 1'b0;
            addr_match    <= 1'b0;
            overrun       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            scl_d_r       <= scl_in;
            sda_d_r       <= sda_in;
            bit_cnt_r     <= bit_cnt_nxt_s;
            byte_full_r   <= byte_full_nxt_s;
            shift_strobe  <= strobe_nxt_s;
            sda_drive_low <= drive_nxt_s;
            byte_valid    <= valid_nxt_s;
            addr_match    <= match_nxt_s;
            overrun       <= overrun_nxt_s;
            busy          <= busy_nxt_s;
        end
    end

endmodule

// File: tb/tb_i2c_slave_rx_ctrl.sv
// ---------------------------------------------------------------------------
// Self-checking bench for i2c_slave_rx_ctrl. Models an I2C master, the
// wired-AND SDA line and the downstream MSB-first shift register; expected
// data bytes are queued as they are sent and compared when byte_valid fires.
// ---------------------------------------------------------------------------
module tb_i2c_slave_rx_ctrl;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       fifo_full = 1'b0;
    logic       scl_in, sda_in;
    logic [7:0] rx_sr;
    logic       shift_strobe, sda_drive_low, byte_valid;
    logic       addr_match, overrun, busy;

    int tests_run = 0;
    int fails = 0;

    // Monitor state (written only by the monitor process).
    int         strobe_cnt = 0;
    int         valid_cnt = 0;
    int         ovr_cnt = 0;
    logic [7:0] cap_mem [0:31];

    // Scoreboard state (written only by the stimulus process).
    logic [7:0] exp_q [$];
    int         rd_idx = 0;

    always #5 clk = ~clk;

    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_drive_low;

    i2c_slave_rx_ctrl dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .scl_in        (scl_in),
        .sda_in        (sda_in),
        .rx_byte       (rx_sr),
        .fifo_full     (fifo_full),
        .shift_strobe  (shift_strobe),
        .sda_drive_low (sda_drive_low),
        .byte_valid    (byte_valid),
        .addr_match    (addr_match),
        .overrun       (overrun),
        .busy          (busy)
    );

    // Downstream shift register: samples SDA on each strobe, MSB first.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) rx_sr <= 8'h00;
        else if (shift_strobe) rx_sr <= {rx_sr[6:0], sda_in};
    end

    // Pulse counters and byte capture, sampled away from the active edge.
    always @(negedge clk) begin
        if (n_rst) begin
            if (shift_strobe) strobe_cnt <= strobe_cnt + 1;
            if (overrun) ovr_cnt <= ovr_cnt + 1;
            if (byte_valid) begin
                cap_mem[valid_cnt[4:0]] <= rx_sr;
                valid_cnt <= valid_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare every byte delivered since the last call against the queue.
    task automatic sb_check(input string tag);
        int n;
        n = valid_cnt - rd_idx;
        check({tag, "_count"}, n, exp_q.size());
        for (int k = 0; k < n; k++) begin
            if (exp_q.size() > 0) check({tag, "_byte"}, cap_mem[(rd_idx + k) % 32], exp_q.pop_front());
        end
        rd_idx = valid_cnt;
        exp_q.delete();
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clks(4);
        scl_m = 1'b1; wait_clks(4);
        sda_m = 1'b0; wait_clks(8);
        scl_m = 1'b0; wait_clks(4);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clks(4);
        scl_m = 1'b1; wait_clks(4);
        sda_m = 1'b1; wait_clks(8);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wait_clks(4);
        scl_m = 1'b1; wait_clks(8);
        scl_m = 1'b0; wait_clks(4);
    endtask

    // Eight data bits then the ACK clock, checking the slave's response.
    task automatic send_byte(input logic [7:0] b, input logic ack_exp, input string tag);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; wait_clks(4);
        scl_m = 1'b1; wait_clks(4);
        check({tag, "_ack"}, sda_drive_low, ack_exp);
        wait_clks(4);
        scl_m = 1'b0; wait_clks(4);
    endtask

    int s0, v0, o0;

    initial begin
        // Reset state
        wait_clks(4);
        check("rst_strobe", shift_strobe, 1'b0);
        check("rst_drive", sda_drive_low, 1'b0);
        check("rst_valid", byte_valid, 1'b0);
        check("rst_match", addr_match, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        n_rst = 1'b1;
        wait_clks(4);

        // Good write: 0x78 then 0xA5, then STOP
        i2c_start();
        check("wr_busy", busy, 1'b1);
        s0 = strobe_cnt;
        send_byte(8'h78, 1'b1, "wr_addr");
        check("wr_addr_strobes", strobe_cnt - s0, 8);
        check("wr_match", addr_match, 1'b1);
        exp_q.push_back(8'hA5);
        s0 = strobe_cnt;
        send_byte(8'hA5, 1'b1, "wr_data");
        check("wr_data_strobes", strobe_cnt - s0, 8);
        check("wr_match_hold", addr_match, 1'b1);
        sb_check("wr");
        i2c_stop();
        check("wr_stop_busy", busy, 1'b0);
        check("wr_stop_match", addr_match, 1'b0);

        // Wrong address (0x3D write) and read request (0x3C read)
        i2c_start();
        send_byte(8'h7A, 1'b0, "bad_addr");
        check("bad_addr_match", addr_match, 1'b0);
        s0 = strobe_cnt;
        send_byte(8'h11, 1'b0, "bad_follow");
        check("bad_follow_strobes", strobe_cnt - s0, 0);
        sb_check("bad");
        i2c_stop();
        i2c_start();
        send_byte(8'h79, 1'b0, "rd_addr");
        check("rd_match", addr_match, 1'b0);
        send_byte(8'h22, 1'b0, "rd_follow");
        sb_check("rd");
        i2c_stop();

        // Repeated START after 4 data bits
        i2c_start();
        send_byte(8'h78, 1'b1, "rs_addr");
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        i2c_start();
        check("rs_match_clr", addr_match, 1'b0);
        check("rs_busy", busy, 1'b1);
        send_byte(8'h78, 1'b1, "rs_addr2");
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1, "rs_data");
        sb_check("rs");
        i2c_stop();

        // Data byte arriving while the FIFO is full
        i2c_start();
        send_byte(8'h78, 1'b1, "ff_addr");
        fifo_full = 1'b1;
        o0 = ovr_cnt;
`ifdef I2C_RX_NACK_ON_FULL_EN
        send_byte(8'h33, 1'b0, "ff_data");
        check("ff_overrun", ovr_cnt - o0, 1);
        fifo_full = 1'b0;
        s0 = strobe_cnt;
        send_byte(8'h44, 1'b0, "ff_next");
        check("ff_next_strobes", strobe_cnt - s0, 0);
`else
        exp_q.push_back(8'h33);
        send_byte(8'h33, 1'b1, "ff_data");
        check("ff_overrun", ovr_cnt - o0, 1);
        fifo_full = 1'b0;
        exp_q.push_back(8'h44);
        send_byte(8'h44, 1'b1, "ff_next");
        check("ff_next_overrun", ovr_cnt - o0, 1);
`endif
        sb_check("ff");
        i2c_stop();

        // STOP in the middle of a data byte
        i2c_start();
        send_byte(8'h78, 1'b1, "ms_addr");
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        i2c_stop();
        check("ms_busy", busy, 1'b0);
        check("ms_drive", sda_drive_low, 1'b0);
        check("ms_match", addr_match, 1'b0);
        sb_check("ms");

        // Reset asserted while the slave is driving the address ACK
        i2c_start();
        v0 = valid_cnt;
        for (int i = 7; i >= 0; i--) send_bit(i == 6 || i == 5 || i == 4 || i == 3);
        sda_m = 1'b1; wait_clks(4);
        scl_m = 1'b1; wait_clks(2);
        check("ar_drive_pre", sda_drive_low, 1'b1);
        #2 n_rst = 1'b0;
        #1;
        check("ar_drive", sda_drive_low, 1'b0);
        check("ar_busy", busy, 1'b0);
        check("ar_match", addr_match, 1'b0);
        check("ar_valid", byte_valid, 1'b0);
        check("ar_strobe", shift_strobe, 1'b0);
        check("ar_overrun", overrun, 1'b0);
        sda_m = 1'b1; scl_m = 1'b1;
        wait_clks(3);
        n_rst = 1'b1;
        rd_idx = valid_cnt;
        wait_clks(4);
        check("ar_idle_busy", busy, 1'b0);

        // Recovery: a normal transfer after reset
        i2c_start();
        send_byte(8'h78, 1'b1, "rc_addr");
        exp_q.push_back(8'hC3);
        send_byte(8'hC3, 1'b1, "rc_data");
        sb_check("rc");
        i2c_stop();
        check("rc_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/i2c_slave_rx_ctrl.md
# i2c_slave_rx_ctrl

Bit-level I2C slave receive controller for the write path. Runs on the system clock and oversamples synchronized SCL/SDA. Detects START/STOP, generates one shift strobe per data bit for the downstream 8-bit MSB-first serial-to-parallel shift register, and checks the address byte. It then drives ACK/NACK and hands each received data byte to the receive FIFO with a one-cycle valid pulse.

## Interface
- SLAVE_ADDR, 7'h3C, 7-bit slave address matched against the first byte after START.
- clk  in  1  system clock; must be at least 8x the SCL rate.
- n_rst  in  1  asynchronous active-low reset.
- scl_in  in  1  SCL, already synchronized to clk.
- sda_in  in  1  SDA, already synchronized to clk.
- rx_byte  in  8  parallel output of the downstream shift register; bit 0 is the most recently shifted bit.
- fifo_full  in  1  receive FIFO cannot accept a byte.
- shift_strobe  out  1  one-cycle pulse; the shift register samples sda_in on this cycle.
- sda_drive_low  out  1  1 = pull SDA low (ACK); 0 = release.
- byte_valid  out  1  one-cycle pulse; rx_byte holds a complete data byte.
- addr_match  out  1  level; high from the address ACK until STOP or START.
- overrun  out  1  one-cycle pulse; a data byte completed while fifo_full = 1.
- busy  out  1  high from START until STOP.

## Operation
- Edge detect uses registered copies scl_d and sda_d.
  - scl_rise = scl_in & ~scl_d; scl_fall = ~scl_in & scl_d.
  - START = scl_in & scl_d & ~sda_in & sda_d.
  - STOP = scl_in & scl_d & sda_in & ~sda_d.
- States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, WAIT_STOP.
- IDLE: START -> ADDR; bit_cnt <= 0; busy <= 1.
- ADDR and DATA:
  - Each scl_rise pulses shift_strobe and increments bit_cnt (3-bit, wraps 7 -> 0).
  - When bit_cnt has wrapped after the 8th rise, the next scl_fall evaluates the byte.
- Address byte, evaluated on that scl_fall:
  - rx_byte[7:1] == SLAVE_ADDR and rx_byte[0] == 0 (write) -> ADDR_ACK; sda_drive_low <= 1; addr_match <= 1.
  - Otherwise, including read requests -> WAIT_STOP; SDA released (NACK).
- Data byte, evaluated on that scl_fall:
  - byte_valid pulses and the FSM goes to DATA_ACK with sda_drive_low <= 1.
  - If fifo_full = 1, overrun pulses instead (see Configuration).
- ADDR_ACK and DATA_ACK: hold SDA low through the ACK clock. On the following scl_fall: release SDA, go to DATA, bit_cnt <= 0. No shift_strobe is issued for the ACK bit.
- WAIT_STOP: ignores SCL and keeps SDA released.
- START in any non-IDLE state (repeated start):
  - Go to ADDR; bit_cnt <= 0; addr_match <= 0; release SDA.
  - No byte_valid for a partial byte.
- STOP in any state: go to IDLE; busy <= 0; addr_match <= 0; release SDA. A partial byte is discarded.
- START/STOP detection takes priority over scl edges in the same cycle. A STOP in the same cycle as a byte-complete scl_fall is impossible because the two require different SCL levels.

## Timing
- Reset values: every output 0; state IDLE; bit_cnt 0; scl_d and sda_d 1.
- shift_strobe is asserted in the cycle after SCL goes high in scl_in, i.e. on the first clk where scl_in = 1 and scl_d = 0.
- rx_byte is valid from the cycle after the 8th shift_strobe onward. It is sampled at the scl_fall at least 4 clk later.
- byte_valid and sda_drive_low rise in the same cycle: the clk where scl_fall is detected after bit 8.
- sda_drive_low falls on the clk of the scl_fall that ends the ACK bit.
- Reset asserted mid-byte: all outputs drop to 0 asynchronously, and SDA is released immediately.

## Configuration
- I2C_RX_NACK_ON_FULL_EN defined:
  - A data byte completing with fifo_full = 1 is NACKed: SDA is released and byte_valid is not pulsed.
  - overrun pulses and the FSM goes to WAIT_STOP.
- Not defined:
  - The byte is ACKed and byte_valid pulses regardless of fifo_full.
  - overrun pulses in the same cycle when fifo_full = 1.
  - The FSM continues in DATA.

## Test plan
- Reset: drive n_rst = 0 mid-transfer -> all outputs 0 immediately; after release, state IDLE and busy = 0.
- Write to address 0x3C (byte 0x78) then data 0xA5, then STOP:
  - exactly 8 shift_strobe pulses per byte;
  - ACK asserted on both the address and data ACK bits;
  - one byte_valid pulse with rx_byte = 0xA5;
  - addr_match high until STOP; busy = 0 after STOP.
- Address 0x3D write (0x7A), or 0x3C read (0x79) -> sda_drive_low stays 0, addr_match = 0, no byte_valid until the next START.
- Repeated START after 4 data bits, then 0x78 and 0x5A -> no byte_valid for the partial byte; one byte_valid with 0x5A.
- fifo_full = 1 on data byte 0x33:
  - with the macro: NACK, overrun = 1 for one cycle, no byte_valid, next byte ignored;
  - without the macro: ACK, both byte_valid and overrun pulse.
- STOP in the middle of a byte -> IDLE, SDA released, no byte_valid, busy = 0.
